// File: rtl/io_cfg_seq_pkg.sv
`default_nettype none
// io_cfg_seq_pkg -- shared types and sizing helpers for the pad cfg sequencer (rev 1.0)
package io_cfg_seq_pkg;

  localparam int DEF_NUM_PADS      = 16;
  localparam int DEF_IOCELL_CFG_W  = 3;
  localparam int DEF_SETTLE_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PARK  = 2'd1,
    ST_APPLY = 2'd2
  } seq_state_e;

  // Pad-ring cfg array at default sizing; pad i occupies element [i].
  typedef logic [DEF_NUM_PADS-1:0][DEF_IOCELL_CFG_W-1:0] pad_cfg_array_t;

  function automatic int idx_width(input int num_pads);
    return (num_pads > 1) ? $clog2(num_pads) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_cfg_settle_timer.sv
`default_nettype none
// io_cfg_settle_timer -- load/decrement down-counter with zero flag for the park interval (rev 1.0)
module io_cfg_settle_timer #(
  parameter int SETTLE_CYCLES = 4,
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/io_cfg_sequencer.sv
`default_nettype none
// io_cfg_sequencer -- owns every pad's io_cell_cfg and applies changes glitch-safely,
// parking the pad in SAFE_CFG for SETTLE_CYCLES before a conflicting cfg is driven (rev 1.0)
module io_cfg_sequencer
  import io_cfg_seq_pkg::*;
#(
  parameter int NUM_PADS      = DEF_NUM_PADS,
  parameter int IOCELL_CFG_W  = DEF_IOCELL_CFG_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter logic [IOCELL_CFG_W-1:0] SAFE_CFG = IOCELL_CFG_W'(1),
  localparam int IDX_W = idx_width(NUM_PADS)
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [IDX_W-1:0]                 req_pad_idx,
  input  logic [IOCELL_CFG_W-1:0]          req_cfg,
  output logic                             done_pulse,
  output logic                             err_pulse,
  output logic                             busy,
  input  logic [IDX_W-1:0]                 rd_pad_idx,
  output logic [IOCELL_CFG_W-1:0]          rd_cfg,
  output logic [NUM_PADS*IOCELL_CFG_W-1:0] io_cell_cfg
);

  typedef logic [NUM_PADS-1:0][IOCELL_CFG_W-1:0] cfg_array_t;

  seq_state_e               state, next_state;
  cfg_array_t               cfg_q;
  logic [IDX_W-1:0]         cap_idx;
  logic [IOCELL_CFG_W-1:0]  cap_cfg;
  logic                     done_q, err_q;

  logic                     req_in_range, rd_in_range;
  logic [IOCELL_CFG_W-1:0]  req_cur_cfg;
  logic                     wr_en, cap_en, tmr_load, tmr_zero, done_d, err_d;
  logic [IDX_W-1:0]         wr_idx;
  logic [IOCELL_CFG_W-1:0]  wr_cfg;

  generate
    if ((1 << IDX_W) == NUM_PADS) begin : g_full_idx
      assign req_in_range = 1'b1;
      assign rd_in_range  = 1'b1;
    end else begin : g_part_idx
      assign req_in_range = (int'(req_pad_idx) < NUM_PADS);
      assign rd_in_range  = (int'(rd_pad_idx) < NUM_PADS);
    end
  endgenerate

  assign req_cur_cfg = req_in_range ? cfg_q[req_pad_idx] : SAFE_CFG;

  io_cfg_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk_in),
    .rst  (reset_in),
    .load (tmr_load),
    .dec  (state == ST_PARK),
    .zero (tmr_zero)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // APPLY is the completion cycle with the new cfg already driven; it accepts
  // like IDLE so a held request lands exactly SETTLE_CYCLES+1 cycles later.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    wr_idx     = cap_idx;
    wr_cfg     = cap_cfg;
    cap_en     = 1'b0;
    tmr_load   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state)
      ST_IDLE, ST_APPLY: begin
        next_state = ST_IDLE;
        if (req_valid) begin
          if (!req_in_range) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if ((req_cfg == req_cur_cfg) || (req_cur_cfg == SAFE_CFG)) begin
            wr_en  = 1'b1;
            wr_idx = req_pad_idx;
            wr_cfg = req_cfg;
            done_d = 1'b1;
          end else begin
            wr_en      = 1'b1;
            wr_idx     = req_pad_idx;
            wr_cfg     = SAFE_CFG;
            cap_en     = 1'b1;
            tmr_load   = 1'b1;
            next_state = ST_PARK;
          end
        end
      end
      ST_PARK: begin
        if (tmr_zero) begin
          wr_en      = 1'b1;
          done_d     = 1'b1;
          next_state = ST_APPLY;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cfg_q   <= {NUM_PADS{SAFE_CFG}};
      cap_idx <= '0;
      cap_cfg <= SAFE_CFG;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        cfg_q[wr_idx] <= wr_cfg;
      end
      if (cap_en) begin
        cap_idx <= req_pad_idx;
        cap_cfg <= req_cfg;
      end
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign req_ready   = (state != ST_PARK);
  assign busy        = ~req_ready;
  assign done_pulse  = done_q;
  assign err_pulse   = err_q;
  assign rd_cfg      = rd_in_range ? cfg_q[rd_pad_idx] : '0;
  assign io_cell_cfg = cfg_q;

endmodule
`default_nettype wire

// File: tb/tb_io_cfg_sequencer.sv
`default_nettype none
// tb_io_cfg_sequencer -- scoreboard bench for io_cfg_sequencer (4-pad main instance, 5-pad range instance)
module tb_io_cfg_sequencer;

  localparam int          NP   = 4;
  localparam int          W    = 3;
  localparam int          SC   = 4;
  localparam logic [2:0]  SAFE = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, done_pulse, err_pulse, busy;
  logic [1:0]  req_pad_idx, rd_pad_idx;
  logic [2:0]  req_cfg, rd_cfg;
  logic [11:0] io_cell_cfg;

  logic        x_valid, x_ready, x_done, x_err, x_busy;
  logic [2:0]  x_idx, x_rd_idx, x_cfg, x_rd_cfg;
  logic [14:0] x_io;

  always #5 clk = ~clk;

  io_cfg_sequencer #(.NUM_PADS(NP), .IOCELL_CFG_W(W), .SETTLE_CYCLES(SC), .SAFE_CFG(SAFE)) dut (
    .clk_in(clk), .reset_in(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pad_idx(req_pad_idx), .req_cfg(req_cfg), .done_pulse(done_pulse), .err_pulse(err_pulse),
    .busy(busy), .rd_pad_idx(rd_pad_idx), .rd_cfg(rd_cfg), .io_cell_cfg(io_cell_cfg)
  );

  io_cfg_sequencer #(.NUM_PADS(5), .IOCELL_CFG_W(W), .SETTLE_CYCLES(SC), .SAFE_CFG(SAFE)) dut_range (
    .clk_in(clk), .reset_in(rst), .req_valid(x_valid), .req_ready(x_ready),
    .req_pad_idx(x_idx), .req_cfg(x_cfg), .done_pulse(x_done), .err_pulse(x_err),
    .busy(x_busy), .rd_pad_idx(x_rd_idx), .rd_cfg(x_rd_cfg), .io_cell_cfg(x_io)
  );

  typedef struct {
    int          cyc;
    logic        err;
    logic [11:0] io;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] model [NP];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] model_word();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  // Issue one request; returns the accepting edge number with time just past it.
  task automatic send(input logic [1:0] idx, input logic [2:0] cfg, input bit hold, output int acc);
    int         waited;
    logic [2:0] cur;
    exp_t       e;
    waited = 0;
    @(negedge clk);
    req_valid   = 1'b1;
    req_pad_idx = idx;
    req_cfg     = cfg;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", {31'd0, req_ready}, 32'd1);
    acc   = cyc + 1;
    cur   = model[idx];
    e.cyc = ((cfg == cur) || (cur == SAFE)) ? acc : acc + SC;
    model[idx] = cfg;
    e.err = 1'b0;
    e.io  = model_word();
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      check("done_missing", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (done_pulse) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, done_pulse}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("err_pulse", {31'd0, err_pulse}, {31'd0, e.err});
        check("io_at_done", {20'd0, io_cell_cfg}, {20'd0, e.io});
      end
    end else if (err_pulse) begin
      check("err_without_done", {31'd0, err_pulse}, 32'd0);
    end
  end

  initial begin
    int         a1, a2;
    logic [11:0] mask;
    rst = 1'b1;
    req_valid = 1'b0; req_pad_idx = '0; req_cfg = '0; rd_pad_idx = '0;
    x_valid = 1'b0; x_idx = '0; x_cfg = '0; x_rd_idx = '0;
    for (int i = 0; i < NP; i++) model[i] = SAFE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_io", {20'd0, io_cell_cfg}, 32'h249);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done_pulse}, 32'd0);
    for (int i = 0; i < NP; i++) begin
      rd_pad_idx = 2'(i);
      #1;
      check("rst_rd_cfg", {29'd0, rd_cfg}, {29'd0, SAFE});
    end
    @(negedge clk);
    rst = 1'b0;

    // Fast path from SAFE.
    send(2'd2, 3'b110, 1'b0, a1);
    check("fast_pad2", {29'd0, io_cell_cfg[6 +: 3]}, 32'd6);
    check("fast_busy", {31'd0, busy}, 32'd0);

    // Slow path 110 -> 011 with park window.
    rd_pad_idx = 2'd2;
    mask = 12'b000_111_000_000;
    send(2'd2, 3'b011, 1'b0, a1);
    for (int k = 0; k < SC; k++) begin
      check("park_pad2", {29'd0, io_cell_cfg[6 +: 3]}, {29'd0, SAFE});
      check("park_ready", {31'd0, req_ready}, 32'd0);
      check("park_busy", {31'd0, busy}, 32'd1);
      check("park_rd", {29'd0, rd_cfg}, {29'd0, SAFE});
      check("park_others", {20'd0, io_cell_cfg & ~mask}, {20'd0, model_word() & ~mask});
      @(posedge clk);
      #1;
    end
    check("apply_pad2", {29'd0, io_cell_cfg[6 +: 3]}, 32'd3);
    check("apply_ready", {31'd0, req_ready}, 32'd1);
    check("apply_rd", {29'd0, rd_cfg}, 32'd3);

    // Same cfg: no park.
    send(2'd2, 3'b011, 1'b0, a1);
    check("same_pad2", {29'd0, io_cell_cfg[6 +: 3]}, 32'd3);

    // Back-to-back with valid held through busy.
    send(2'd1, 3'b100, 1'b0, a1);
    send(2'd1, 3'b111, 1'b1, a1);
    send(2'd3, 3'b101, 1'b0, a2);
    check("b2b_accept", a2, a1 + SC + 1);

    // Reset in the middle of a slow change.
    send(2'd0, 3'b110, 1'b0, a1);
    send(2'd0, 3'b011, 1'b0, a1);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < NP; i++) model[i] = SAFE;
    @(posedge clk);
    #1;
    check("midrst_io", {20'd0, io_cell_cfg}, 32'h249);
    check("midrst_done", {31'd0, done_pulse}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);

    // Varied traffic through the scoreboard.
    for (int n = 0; n < 8; n++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b0, a1);
    end
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 32'd0);
    check("final_io", {20'd0, io_cell_cfg}, {20'd0, model_word()});

    // Out-of-range index on the 5-pad instance.
    @(negedge clk);
    x_valid = 1'b1; x_idx = 3'd5; x_cfg = 3'b110;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    check("oor_err", {31'd0, x_err}, 32'd1);
    check("oor_done", {31'd0, x_done}, 32'd1);
    check("oor_io", {17'd0, x_io}, 32'h1249);
    check("oor_ready", {31'd0, x_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("oor_err_clear", {31'd0, x_err}, 32'd0);
    x_rd_idx = 3'd6;
    #1;
    check("oor_rd", {29'd0, x_rd_cfg}, 32'd0);
    @(negedge clk);
    x_valid = 1'b1; x_idx = 3'd4; x_cfg = 3'b110;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    x_rd_idx = 3'd4;
    #1;
    check("pad4_done", {31'd0, x_done}, 32'd1);
    check("pad4_err", {31'd0, x_err}, 32'd0);
    check("pad4_io", {17'd0, x_io}, 32'h6249);
    check("pad4_rd", {29'd0, x_rd_cfg}, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
